// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB demultiplexer
package apb_pkg;

    localparam int APB_PROT_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    // Width of the completer index; a single completer still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_demux_if.sv
// rtl/apb_demux_if.sv - upstream requester and downstream completer buses of the APB demultiplexer
interface apb_demux_if #(
    parameter int NUM_APB_SLAVES = 8,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32
);
    logic                                           PSEL_s;
    logic                                           PENABLE_s;
    logic                                           PWRITE_s;
    logic [APB_ADDR_WIDTH-1:0]                      PADDR_s;
    logic [APB_DATA_WIDTH-1:0]                      PWDATA_s;
    logic [APB_DATA_WIDTH/8-1:0]                    PSTRB_s;
    logic [apb_pkg::APB_PROT_W-1:0]                 PPROT_s;
    logic [APB_DATA_WIDTH-1:0]                      PRDATA_s;
    logic                                           PREADY_s;
    logic                                           PSLVERR_s;

    logic [NUM_APB_SLAVES-1:0]                      PSEL_m;
    logic                                           PENABLE_m;
    logic                                           PWRITE_m;
    logic [APB_ADDR_WIDTH-1:0]                      PADDR_m;
    logic [APB_DATA_WIDTH-1:0]                      PWDATA_m;
    logic [APB_DATA_WIDTH/8-1:0]                    PSTRB_m;
    logic [apb_pkg::APB_PROT_W-1:0]                 PPROT_m;
    logic [NUM_APB_SLAVES-1:0][APB_DATA_WIDTH-1:0]  PRDATA_m;
    logic [NUM_APB_SLAVES-1:0]                      PREADY_m;
    logic [NUM_APB_SLAVES-1:0]                      PSLVERR_m;

    modport slave (
        input  PSEL_s, PENABLE_s, PWRITE_s, PADDR_s, PWDATA_s, PSTRB_s, PPROT_s,
        output PRDATA_s, PREADY_s, PSLVERR_s,
        output PSEL_m, PENABLE_m, PWRITE_m, PADDR_m, PWDATA_m, PSTRB_m, PPROT_m,
        input  PRDATA_m, PREADY_m, PSLVERR_m
    );

    modport master (
        output PSEL_s, PENABLE_s, PWRITE_s, PADDR_s, PWDATA_s, PSTRB_s, PPROT_s,
        input  PRDATA_s, PREADY_s, PSLVERR_s,
        input  PSEL_m, PENABLE_m, PWRITE_m, PADDR_m, PWDATA_m, PSTRB_m, PPROT_m,
        output PRDATA_m, PREADY_m, PSLVERR_m
    );

endinterface

// File: rtl/apb_addr_decoder.sv
// rtl/apb_addr_decoder.sv - maps an APB address onto a completer window index and a hit flag
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int                      NUM_APB_SLAVES = 8,
    parameter int                      APB_ADDR_WIDTH = 32,
    parameter int                      SLAVE_ADDR_LSB = 12,
    parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR    = 32'h4000_0000,
    localparam int                     IDX_W          = idx_width(NUM_APB_SLAVES)
) (
    input  logic [APB_ADDR_WIDTH-1:0] paddr,
    output logic [IDX_W-1:0]          idx,
    output logic                      hit
);

    localparam int HI_LSB = SLAVE_ADDR_LSB + IDX_W;

    logic hi_match;
    logic idx_ok;

    assign idx      = paddr[SLAVE_ADDR_LSB +: IDX_W];
    assign hi_match = (paddr >> HI_LSB) == (BASE_ADDR >> HI_LSB);

    // With a power-of-two completer count every index value is populated.
    if (NUM_APB_SLAVES == (1 << IDX_W)) begin : g_full
        assign idx_ok = 1'b1;
    end else begin : g_partial
        assign idx_ok = 32'(idx) < 32'(NUM_APB_SLAVES);
    end

    assign hit = hi_match && idx_ok;

endmodule

// File: rtl/apb_demux.sv
// rtl/apb_demux.sv - one APB requester replayed onto one of N completer windows with local error/timeout termination
module apb_demux
    import apb_pkg::*;
#(
    parameter int                        NUM_APB_SLAVES = 8,
    parameter int                        APB_ADDR_WIDTH = 32,
    parameter int                        APB_DATA_WIDTH = 32,
    parameter int                        SLAVE_ADDR_LSB = 12,
    parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h4000_0000,
    parameter int                        TIMEOUT_CYCLES = 256
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    apb_demux_if.slave  bus,
    output logic        timeout_pulse
);

    localparam int IDX_W  = idx_width(NUM_APB_SLAVES);
    localparam int STRB_W = APB_DATA_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN  = TIMEOUT_CYCLES > 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    apb_state_t                state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                      write_q, write_d;
    logic [STRB_W-1:0]         strb_q, strb_d;
    logic [APB_PROT_W-1:0]     prot_q, prot_d;
    logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      err_q, err_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    logic [IDX_W-1:0]          dec_idx;
    logic                      dec_hit;
    logic                      sel_ready;
    logic                      sel_err;
    logic [APB_DATA_WIDTH-1:0] sel_rdata;
    logic                      resp;
    logic                      busy;

    apb_addr_decoder #(
        .NUM_APB_SLAVES (NUM_APB_SLAVES),
        .APB_ADDR_WIDTH (APB_ADDR_WIDTH),
        .SLAVE_ADDR_LSB (SLAVE_ADDR_LSB),
        .BASE_ADDR      (BASE_ADDR)
    ) u_dec (
        .paddr (bus.PADDR_s),
        .idx   (dec_idx),
        .hit   (dec_hit)
    );

    assign sel_ready = bus.PREADY_m[idx_q];
    assign sel_err   = bus.PSLVERR_m[idx_q];
    assign sel_rdata = bus.PRDATA_m[idx_q];

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        write_d       = write_q;
        strb_d        = strb_q;
        prot_d        = prot_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        cnt_d         = cnt_q;
        timeout_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.PSEL_s && !bus.PENABLE_s) begin
                    idx_d   = dec_idx;
                    addr_d  = bus.PADDR_s;
                    wdata_d = bus.PWDATA_s;
                    write_d = bus.PWRITE_s;
                    strb_d  = bus.PSTRB_s;
                    prot_d  = bus.PPROT_s;
                    rdata_d = '0;
                    err_d   = !dec_hit;
                    cnt_d   = '0;
                    state_d = dec_hit ? SETUP : RESP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // A completer answering in the final allowed cycle still wins over the abort.
                if (sel_ready) begin
                    err_d   = sel_err;
                    rdata_d = (!write_q && !sel_err) ? sel_rdata : '0;
                    state_d = RESP;
                end else if (TO_EN && cnt_q == CNT_LAST) begin
                    timeout_pulse = 1'b1;
                    err_d         = 1'b1;
                    rdata_d       = '0;
                    state_d       = RESP;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            strb_q  <= '0;
            prot_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            strb_q  <= strb_d;
            prot_q  <= prot_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign resp = state_q == RESP;
    assign busy = (state_q == SETUP) || (state_q == ACCESS);

    assign bus.PSEL_m    = busy ? (NUM_APB_SLAVES'(1) << idx_q) : '0;
    assign bus.PENABLE_m = state_q == ACCESS;
    assign bus.PWRITE_m  = write_q;
    assign bus.PADDR_m   = addr_q;
    assign bus.PWDATA_m  = wdata_q;
    assign bus.PSTRB_m   = strb_q;
    assign bus.PPROT_m   = prot_q;

    assign bus.PREADY_s  = resp;
    assign bus.PSLVERR_s = resp && err_q;
    assign bus.PRDATA_s  = resp ? rdata_q : '0;

endmodule

// File: tb/tb_apb_demux.sv
// tb/tb_apb_demux.sv - self-checking bench for apb_demux with a behavioural completer set
module tb_apb_demux;
    import apb_pkg::*;

    localparam int N  = 8;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    typedef struct {
        logic [AW-1:0] addr;
        bit            write;
        logic [DW-1:0] wdata;
        int            waits;
        bit            hang;
        bit            serr;
        logic [DW-1:0] rdata;
        bit            drop;
    } vec_t;

    typedef struct {
        int            lat;
        bit            err;
        logic [DW-1:0] rd;
        int            psel_cyc;
        int            tout;
        logic [N-1:0]  sel;
    } exp_t;

    logic PCLK = 1'b0;
    logic PRESETn;
    logic timeout_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int            s_wait [N];
    bit            s_hang [N];
    bit            s_err  [N];
    logic [DW-1:0] s_data [N];
    int            acc    = 0;
    logic [DW-1:0] noise  = '0;

    always #5 PCLK = ~PCLK;

    apb_demux_if #(.NUM_APB_SLAVES(N), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) bus ();

    apb_demux #(
        .NUM_APB_SLAVES (N),
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW),
        .SLAVE_ADDR_LSB (12),
        .BASE_ADDR      (32'h4000_0000),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK          (PCLK),
        .PRESETn       (PRESETn),
        .bus           (bus),
        .timeout_pulse (timeout_pulse)
    );

    always @(posedge PCLK) begin
        cyc   <= cyc + 1;
        noise <= $urandom;
        if ((|bus.PSEL_m) && bus.PENABLE_m) acc <= acc + 1;
        else                                acc <= 0;
    end

    // Completers: the selected one follows its configuration, the rest shout garbage.
    always_comb begin
        bus.PREADY_m  = '1;
        bus.PSLVERR_m = '1;
        bus.PRDATA_m  = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.PSEL_m[i]) begin
                bus.PREADY_m[i]  = bus.PENABLE_m && !s_hang[i] && (acc >= s_wait[i]);
                bus.PSLVERR_m[i] = s_err[i];
                bus.PRDATA_m[i]  = s_data[i];
            end else begin
                bus.PRDATA_m[i]  = noise ^ DW'(i);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input vec_t v);
        exp_t e;
        bit   mapped;
        int   idx;
        mapped = (v.addr >> 15) == (32'h4000_0000 >> 15);
        idx    = int'(v.addr[14:12]);
        e.lat = 1; e.err = 1'b1; e.rd = '0; e.psel_cyc = 0; e.tout = 0; e.sel = '0;
        if (mapped) begin
            e.sel = N'(1) << idx;
            if (v.hang || v.waits >= TO) begin
                e.lat = TO + 2; e.psel_cyc = TO + 1; e.tout = 1;
            end else begin
                e.lat      = v.waits + 3;
                e.psel_cyc = v.waits + 2;
                e.err      = v.serr;
                e.rd       = (!v.write && !v.serr) ? v.rdata : '0;
            end
        end
        return e;
    endfunction

    function automatic vec_t mk(input logic [AW-1:0] a, input bit w, input logic [DW-1:0] wd,
                                input int ws, input bit h, input bit se, input logic [DW-1:0] rd,
                                input bit dr);
        vec_t v;
        v.addr = a; v.write = w; v.wdata = wd; v.waits = ws;
        v.hang = h; v.serr = se; v.rdata = rd; v.drop = dr;
        return v;
    endfunction

    task automatic idle(input int n);
        bus.PSEL_s    = 1'b0;
        bus.PENABLE_s = 1'b0;
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic run(input vec_t v, input string tag, output int start_cyc);
        exp_t                  e;
        int                    idx;
        int                    lat, psel_cyc, tout, tout_k, bad_sel, bad_bc, bad_resp;
        logic                  perr;
        logic [DW-1:0]         prd;
        logic [DW/8-1:0]       strb;
        logic [APB_PROT_W-1:0] prot;
        e    = model(v);
        idx  = int'(v.addr[14:12]);
        s_wait[idx] = v.waits; s_hang[idx] = v.hang; s_err[idx] = v.serr; s_data[idx] = v.rdata;
        strb = (DW/8)'($urandom);
        prot = APB_PROT_W'($urandom);
        lat = -1; psel_cyc = 0; tout = 0; tout_k = 0; bad_sel = 0; bad_bc = 0; bad_resp = 0;
        perr = 1'bx; prd = 'x;
        @(posedge PCLK); #1;
        start_cyc     = cyc;
        bus.PSEL_s    = 1'b1;
        bus.PENABLE_s = 1'b0;
        bus.PADDR_s   = v.addr;
        bus.PWRITE_s  = v.write;
        bus.PWDATA_s  = v.wdata;
        bus.PSTRB_s   = strb;
        bus.PPROT_s   = prot;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(posedge PCLK); #1;
            if (bus.PSEL_m != '0) begin
                psel_cyc++;
                if (bus.PSEL_m !== e.sel) bad_sel++;
                if (bus.PADDR_m !== v.addr || bus.PWRITE_m !== v.write || bus.PWDATA_m !== v.wdata ||
                    bus.PSTRB_m !== strb || bus.PPROT_m !== prot || bus.PENABLE_m !== (psel_cyc > 1))
                    bad_bc++;
            end
            if (timeout_pulse) begin tout++; tout_k = k; end
            if (bus.PREADY_s) begin
                lat = k; perr = bus.PSLVERR_s; prd = bus.PRDATA_s;
            end else if (bus.PSLVERR_s || bus.PRDATA_s != '0) begin
                bad_resp++;
            end
            if (k == 1) begin
                if (v.drop) begin bus.PSEL_s = 1'b0; bus.PENABLE_s = 1'b0; end
                else        bus.PENABLE_s = 1'b1;
            end
        end
        chk({tag, " latency"},      64'(lat),      64'(e.lat));
        chk({tag, " pslverr"},      64'(perr),     64'(e.err));
        chk({tag, " prdata"},       64'(prd),      64'(e.rd));
        chk({tag, " psel cycles"},  64'(psel_cyc), 64'(e.psel_cyc));
        chk({tag, " timeouts"},     64'(tout),     64'(e.tout));
        chk({tag, " timeout cyc"},  64'(tout_k),   64'(e.tout ? e.lat - 1 : 0));
        chk({tag, " bad psel"},     64'(bad_sel),  64'd0);
        chk({tag, " bad bcast"},    64'(bad_bc),   64'd0);
        chk({tag, " early resp"},   64'(bad_resp), 64'd0);
    endtask

    vec_t tbl [13];

    initial begin
        int   st, prev_st, prev_lat, bad;
        vec_t v;

        tbl[0]  = mk(32'h4000_2004, 1'b1, 32'h1234_5678, 0, 1'b0, 1'b0, 32'h0,         1'b0);
        tbl[1]  = mk(32'h4000_5000, 1'b0, 32'h0,         3, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0);
        tbl[2]  = mk(32'h4000_9000, 1'b0, 32'h0,         0, 1'b0, 1'b0, 32'h1111_1111, 1'b0);
        tbl[3]  = mk(32'h5000_0000, 1'b0, 32'h0,         0, 1'b0, 1'b0, 32'h2222_2222, 1'b0);
        tbl[4]  = mk(32'h4000_1000, 1'b0, 32'h0,         0, 1'b1, 1'b0, 32'h3333_3333, 1'b0);
        tbl[5]  = mk(32'h4000_1008, 1'b0, 32'h0,         0, 1'b0, 1'b0, 32'hCAFE_0001, 1'b0);
        tbl[6]  = mk(32'h4000_3000, 1'b0, 32'h0,         1, 1'b0, 1'b1, 32'h4444_4444, 1'b0);
        tbl[7]  = mk(32'h4000_0FFC, 1'b0, 32'h0,         0, 1'b0, 1'b0, 32'hA5A5_5A5A, 1'b0);
        tbl[8]  = mk(32'h4000_7FFC, 1'b1, 32'h7777_0007, 0, 1'b0, 1'b0, 32'h0,         1'b0);
        tbl[9]  = mk(32'h4000_4000, 1'b0, 32'h0,         4, 1'b0, 1'b0, 32'h5555_5555, 1'b0);
        tbl[10] = mk(32'h4000_6000, 1'b0, 32'h0,         1, 1'b0, 1'b0, 32'h0000_600D, 1'b1);
        tbl[11] = mk(32'h4000_3010, 1'b1, 32'h9999_0000, 2, 1'b0, 1'b1, 32'h0,         1'b0);
        tbl[12] = mk(32'h4000_0000, 1'b0, 32'h0,         0, 1'b0, 1'b0, 32'h0BAD_F00D, 1'b0);

        for (int i = 0; i < N; i++) begin
            s_wait[i] = 0; s_hang[i] = 1'b0; s_err[i] = 1'b0; s_data[i] = '0;
        end
        PRESETn       = 1'b0;
        bus.PSEL_s    = 1'b0;
        bus.PENABLE_s = 1'b0;
        bus.PWRITE_s  = 1'b0;
        bus.PADDR_s   = '0;
        bus.PWDATA_s  = '0;
        bus.PSTRB_s   = '0;
        bus.PPROT_s   = '0;
        #3;
        chk("reset ctrl", 64'({bus.PSEL_m, bus.PENABLE_m, bus.PWRITE_m, bus.PSTRB_m, bus.PPROT_m,
                               bus.PREADY_s, bus.PSLVERR_s, timeout_pulse}), 64'd0);
        chk("reset paddr",  64'(bus.PADDR_m),  64'd0);
        chk("reset pwdata", 64'(bus.PWDATA_m), 64'd0);
        chk("reset prdata", 64'(bus.PRDATA_s), 64'd0);
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;

        prev_st = 0; prev_lat = 0;
        for (int i = 0; i < 13; i++) begin
            run(tbl[i], $sformatf("vec%0d", i), st);
            if (i > 0) chk($sformatf("vec%0d b2b start", i), 64'(st - prev_st), 64'(prev_lat + 1));
            prev_st  = st;
            prev_lat = model(tbl[i]).lat;
        end

        idle(3);
        chk("hold paddr",  64'(bus.PADDR_m),  64'(tbl[12].addr));
        chk("hold pwrite", 64'(bus.PWRITE_m), 64'd0);
        run(tbl[8], "hold wr", st);
        idle(2);
        chk("hold pwdata", 64'(bus.PWDATA_m), 64'(tbl[8].wdata));

        // Reset in the middle of an ACCESS phase towards a hung completer.
        s_hang[1] = 1'b1;
        @(posedge PCLK); #1;
        bus.PSEL_s = 1'b1; bus.PENABLE_s = 1'b0; bus.PADDR_s = 32'h4000_1010; bus.PWRITE_s = 1'b0;
        @(posedge PCLK); #1;
        bus.PENABLE_s = 1'b1;
        @(posedge PCLK); #1;
        chk("pre-reset access", 64'({bus.PSEL_m, bus.PENABLE_m}), 64'({8'b0000_0010, 1'b1}));
        #2 PRESETn = 1'b0;
        #1;
        chk("mid reset ctrl", 64'({bus.PSEL_m, bus.PENABLE_m, bus.PREADY_s, bus.PSLVERR_s, timeout_pulse}), 64'd0);
        chk("mid reset paddr", 64'(bus.PADDR_m), 64'd0);
        bus.PSEL_s = 1'b0; bus.PENABLE_s = 1'b0; s_hang[1] = 1'b0;
        @(posedge PCLK); #3 PRESETn = 1'b1;
        bad = 0;
        repeat (4) begin
            @(posedge PCLK); #1;
            if (bus.PREADY_s || (|bus.PSEL_m)) bad++;
        end
        chk("post reset quiet", 64'(bad), 64'd0);
        run(mk(32'h4000_1010, 1'b0, 32'h0, 1, 1'b0, 1'b0, 32'h1357_9BDF, 1'b0), "post reset", st);

        for (int i = 0; i < 40; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 8)       v.addr = 32'h4000_0000 | (32'(r) << 12) | ($urandom & 32'hFFC);
            else if (r == 8) v.addr = 32'h4000_8000 | ($urandom & 32'h7FFC);
            else             v.addr = $urandom;
            v.write = 1'($urandom);
            v.wdata = $urandom;
            v.waits = int'($urandom_range(0, 5));
            v.hang  = ($urandom_range(0, 9) == 0);
            v.serr  = ($urandom_range(0, 4) == 0);
            v.rdata = $urandom;
            v.drop  = ($urandom_range(0, 7) == 0);
            run(v, $sformatf("rnd%0d", i), st);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/apb_demux.md
# apb_demux

Single-upstream to N-downstream APB splitter. It takes one APB requester, decodes PADDR into one of NUM_APB_SLAVES fixed windows, and replays the transfer on the selected completer with registered SETUP/ACCESS phases. It returns a registered response upstream. Unmapped addresses and hung completers are terminated locally with PSLVERR. It sits between the shared output of the APB mux and the peripheral completers.

## Interface
Parameters:
- NUM_APB_SLAVES, 8, number of downstream completers (≥1)
- APB_ADDR_WIDTH, 32, address width
- APB_DATA_WIDTH, 32, data width (multiple of 8)
- SLAVE_ADDR_LSB, 12, log2 of window size; slave index = PADDR[SLAVE_ADDR_LSB +: IDX_W], IDX_W = max(1, $clog2(NUM_APB_SLAVES))
- BASE_ADDR, 32'h4000_0000, region base; only bits above SLAVE_ADDR_LSB+IDX_W are compared
- TIMEOUT_CYCLES, 256, ACCESS cycles allowed before local abort; 0 disables

Ports (one clock; reset is asynchronous and active-low):
- PCLK  in  1  clock
- PRESETn  in  1  async active-low reset
- PSEL_s, PENABLE_s, PWRITE_s  in  1 each  upstream control
- PADDR_s  in  APB_ADDR_WIDTH  upstream address
- PWDATA_s  in  APB_DATA_WIDTH  write data
- PSTRB_s  in  APB_DATA_WIDTH/8  byte strobes
- PPROT_s  in  3  protection
- PRDATA_s  out  APB_DATA_WIDTH  read data, registered
- PREADY_s, PSLVERR_s  out  1 each  registered response
- PSEL_m  out  NUM_APB_SLAVES  one-hot select
- PENABLE_m, PWRITE_m  out  1 each  broadcast
- PADDR_m, PWDATA_m, PSTRB_m, PPROT_m  out  widths as upstream  broadcast, full address passed
- PRDATA_m  in  [APB_DATA_WIDTH] × NUM_APB_SLAVES  per-completer read data
- PREADY_m, PSLVERR_m  in  NUM_APB_SLAVES  per-completer response
- timeout_pulse  out  1  one-cycle pulse on local abort

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: accept when PSEL_s=1 & PENABLE_s=0. Latch PADDR/PWRITE/PWDATA/PSTRB/PPROT and the decoded index.
  - Mapped: high address bits equal BASE_ADDR and index < NUM_APB_SLAVES. Go to SETUP.
  - Unmapped: go to RESP with error flag set; no downstream activity.
- SETUP: PSEL_m[idx]=1, PENABLE_m=0. Go to ACCESS.
- ACCESS: PSEL_m[idx]=1, PENABLE_m=1. The timeout counter increments each cycle.
  - PREADY_m[idx]=1: capture PRDATA_m[idx] and PSLVERR_m[idx], then go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 with PREADY_m[idx] still low: abort. Pulse timeout_pulse, set the error flag, set read data to 0, then go to RESP.
- RESP: downstream idle (PSEL_m=0, PENABLE_m=0). PREADY_s=1 for exactly one cycle, with PRDATA_s/PSLVERR_s valid.
  - Reads: PRDATA_s is the captured data.
  - Writes and errors: PRDATA_s=0.
  - Then return to IDLE.
- PREADY_s=0, PSLVERR_s=0 and PRDATA_s=0 in every state except RESP.
- PREADY/PSLVERR/PRDATA of non-selected completers are ignored.
- Upstream PSEL_s dropping mid-transfer (protocol violation): the downstream transfer still completes, and the RESP cycle is still generated.
- Broadcast PADDR_m/PWDATA_m/PWRITE_m/PSTRB_m/PPROT_m hold their latched values until the next accept.

## Timing
- Reset (async assert, sync deassert at the user's discretion): state IDLE, counter 0. All outputs are 0: PSEL_m, PENABLE_m, PADDR_m, PWDATA_m, PWRITE_m, PSTRB_m, PPROT_m, PRDATA_s, PREADY_s, PSLVERR_s, timeout_pulse.
- Reset asserted mid-transfer drops PSEL_m/PENABLE_m immediately. No response is issued.
- Mapped transfer, zero-wait completer:
  - T0: upstream setup.
  - T1: PSEL_m.
  - T2: PENABLE_m, PREADY_m sampled.
  - T3: PREADY_s=1.
  - Result: two upstream wait states. Each completer wait state adds one cycle.
- Unmapped transfer: PREADY_s=1, PSLVERR_s=1 in T1 (zero wait states).
- Timeout: PSEL_m high for 1 + TIMEOUT_CYCLES cycles. timeout_pulse fires in the last ACCESS cycle; PREADY_s follows in the next cycle.
- Back-to-back: a new setup presented the cycle after RESP is accepted in that cycle. Minimum mapped transfer is 4 cycles.
- Counter clears on entry to SETUP. Counter width is $clog2(TIMEOUT_CYCLES+1).

## Structure
- Shared package apb_pkg: apb_state_t enum (IDLE, SETUP, ACCESS, RESP), APB_PROT_W=3 constant.
- Sub-module apb_addr_decoder: combinational; PADDR in; index and hit out.
- FSM, capture registers and timeout counter live in apb_demux.

## Test plan
- Write to 0x4000_2004 with zero-wait slave 2: PSEL_m=8'b0000_0100 in T1, PENABLE_m in T2, PADDR_m=0x4000_2004, PREADY_s=1 and PSLVERR_s=0 in T3.
- Read from 0x4000_5000, slave 5 inserts 3 waits and returns 0xDEAD_BEEF: PREADY_s in T6 with PRDATA_s=0xDEAD_BEEF; other slaves' PRDATA ignored.
- Read from 0x4000_9000 (index 9 ≥ 8) and from 0x5000_0000: no PSEL_m; PREADY_s=1, PSLVERR_s=1, PRDATA_s=0 in T1.
- TIMEOUT_CYCLES=4, slave 1 never ready: PSEL_m[1] high for 5 cycles, timeout_pulse in the last one, then PREADY_s=1 with PSLVERR_s=1; the next transfer proceeds normally.
- Slave 3 returns PSLVERR_m=1: PSLVERR_s=1 in RESP.
- Back-to-back transfers to slaves 0 then 7: one transfer each per 4 cycles.
- PRESETn pulsed low during ACCESS: all outputs 0 immediately; the next transfer completes normally.
